opc_intc: RTL and testbench

Parametrised interrupt controller for OPC-family CPUs. It replaces the two hard-wired `int_b` lines with `NUM_INT` maskable sources, each configurable as edge or level, each routed to one of the CPU's two interrupt lines. Software reads a vector ID register to find the winning source, and that read acknowledges it. The block sits on the CPU I/O bus (`vio` cycles) and drives the CPU `int_b[1:0]` inputs directly.

---
 rtl/opc_intc_pkg.sv | 19 +
 rtl/opc_intc_chan.sv | 29 ++
 rtl/opc_intc.sv | 86 ++++++++
 tb/tb_opc_intc.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/opc_intc_pkg.sv
// opc_intc_pkg: register map, sizing and priority helper for the OPC interrupt controller
package opc_intc_pkg;
    localparam int MAX_INT = 16;
    localparam logic [2:0] REG_PEND  = 3'd0;
    localparam logic [2:0] REG_MASK  = 3'd1;
    localparam logic [2:0] REG_MODE  = 3'd2;
    localparam logic [2:0] REG_PRIO  = 3'd3;
    localparam logic [2:0] REG_VECID = 3'd4;
    localparam logic [2:0] REG_SWSET = 3'd5;
    localparam int VEC_HI    = 15;
    localparam int VEC_VALID = 14;

    // Returns {found, index} of the lowest set bit
    function automatic logic [4:0] first_set(input logic [MAX_INT-1:0] v);
        first_set = '0;
        for (int i = MAX_INT - 1; i >= 0; i--)
            if (v[i]) first_set = {1'b1, 4'(i)};
    endfunction
endpackage

// File: rtl/opc_intc_chan.sv
// opc_intc_chan: one interrupt source - synchroniser, edge detect and pending latch
module opc_intc_chan (
    input  logic clk,
    input  logic reset,
    input  logic clken,
    input  logic irq_in,
    input  logic mode,
    input  logic set,
    input  logic clear,
    output logic pending
);
    logic sync1, sync2, s_prev, pend_edge;

    // Set beats clear; leaving edge mode drops the latched request
    always_ff @(posedge clk) begin
        if (clken) begin
            if (reset) begin
                {sync1, sync2, s_prev, pend_edge} <= '0;
            end else begin
                sync1     <= irq_in;
                sync2     <= sync1;
                s_prev    <= sync2;
                pend_edge <= mode & ((sync2 & ~s_prev) | set | (pend_edge & ~clear));
            end
        end
    end

    assign pending = mode ? pend_edge : sync2;
endmodule

// File: rtl/opc_intc.sv
// opc_intc: maskable edge/level interrupt controller on the OPC I/O bus
module opc_intc
    import opc_intc_pkg::*;
#(
    parameter int          NUM_INT   = 8,
    parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clken,
    input  logic [NUM_INT-1:0] irq_in,
    input  logic               vio,
    input  logic               rnw,
    input  logic [15:0]        address,
    input  logic [15:0]        wdata,
    output logic [15:0]        rdata,
    output logic               sel,
    output logic [1:0]         int_b
);
    localparam logic [MAX_INT-1:0] VALID = MAX_INT'((32'd1 << NUM_INT) - 32'd1);

    logic [15:0] off, vecid, ack_vec, set, clr;
    logic [MAX_INT-1:0] mask_r, mode_r, prio_r, pend, irq_ext, act_hi, act_lo;
    logic [4:0] win_hi, win_lo;
    logic [2:0] reg_off;
    logic wr_en, rd_en;

    assign off     = address - BASE_ADDR;
    assign sel     = vio && off < 16'd6;
    assign reg_off = off[2:0];
    assign wr_en   = clken && sel && !rnw;
    assign rd_en   = clken && sel && rnw;
    assign irq_ext = MAX_INT'(irq_in);

    // Channels above NUM_INT see a constant 0 and level mode, so they never pend
    for (genvar i = 0; i < MAX_INT; i++) begin : g_chan
        opc_intc_chan u_chan (
            .clk(clk), .reset(reset), .clken(clken), .irq_in(irq_ext[i]),
            .mode(mode_r[i]), .set(set[i]), .clear(clr[i]), .pending(pend[i])
        );
    end

    assign act_hi = pend & mask_r & prio_r;
    assign act_lo = pend & mask_r & ~prio_r;
    assign win_hi = first_set(act_hi);
    assign win_lo = first_set(act_lo);

    // High group wins over low group; lowest index wins inside a group
    always_comb begin
        vecid            = '0;
        vecid[VEC_HI]    = win_hi[4];
        vecid[VEC_VALID] = win_hi[4] | win_lo[4];
        vecid[3:0]       = win_hi[4] ? win_hi[3:0] : win_lo[3:0];
    end

    assign ack_vec = rd_en && reg_off == REG_VECID && vecid[VEC_VALID] ? 16'd1 << vecid[3:0] : '0;
    assign clr     = (wr_en && reg_off == REG_PEND ? wdata : '0) | ack_vec;
    assign set     = wr_en && reg_off == REG_SWSET ? wdata : '0;

    // Configuration registers; bits at or above NUM_INT stay zero
    always_ff @(posedge clk) begin
        if (clken) begin
            if (reset) begin
                mask_r <= '0;
                mode_r <= '0;
                prio_r <= '0;
            end else if (wr_en) begin
                if (reg_off == REG_MASK) mask_r <= wdata & VALID;
                if (reg_off == REG_MODE) mode_r <= wdata & VALID;
                if (reg_off == REG_PRIO) prio_r <= wdata & VALID;
            end
        end
    end

    assign rdata = !sel                 ? '0     :
                   reg_off == REG_PEND  ? pend   :
                   reg_off == REG_MASK  ? mask_r :
                   reg_off == REG_MODE  ? mode_r :
                   reg_off == REG_PRIO  ? prio_r :
                   reg_off == REG_VECID ? vecid  : '0;

    // Registered active-low group requests
    always_ff @(posedge clk) begin
        if (clken) int_b <= reset ? 2'b11 : {~|act_hi, ~|act_lo};
    end
endmodule

// File: tb/tb_opc_intc.sv
// tb_opc_intc: directed checks of the OPC interrupt controller
module tb_opc_intc;
    localparam logic [15:0] BASE = 16'hFF00;

    logic clk = 0, reset = 0, clken = 1, vio = 0, rnw = 1;
    logic [7:0] irq_in = '0;
    logic [15:0] address = '0, wdata = '0, rdata;
    logic sel;
    logic [1:0] int_b;
    int n_run = 0, n_fail = 0;

    opc_intc #(.NUM_INT(8), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .clken(clken), .irq_in(irq_in), .vio(vio),
        .rnw(rnw), .address(address), .wdata(wdata), .rdata(rdata), .sel(sel), .int_b(int_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] off, input logic [15:0] d);
        address = BASE + 16'(off);
        wdata = d;
        rnw = 0;
        vio = 1;
        tick();
        vio = 0;
        rnw = 1;
    endtask

    task automatic rd(input logic [2:0] off, input logic [15:0] exp, input string tag);
        address = BASE + 16'(off);
        rnw = 1;
        vio = 1;
        #1;
        check(tag, rdata, exp);
        tick();
        vio = 0;
    endtask

    initial begin
        reset = 1;
        tick(2);
        reset = 0;
        check("rst_int_b", 16'(int_b), 16'h0003);
        check("unsel_rdata", rdata, 16'h0000);
        rd(0, 16'h0000, "rst_pend");
        rd(1, 16'h0000, "rst_mask");
        rd(2, 16'h0000, "rst_mode");
        rd(3, 16'h0000, "rst_prio");
        rd(4, 16'h0000, "rst_vecid");
        address = BASE + 16'd6;
        vio = 1;
        #1;
        check("sel_out_of_range", 16'(sel), 16'h0000);
        address = BASE + 16'd5;
        #1;
        check("sel_in_range", 16'(sel), 16'h0001);
        vio = 0;

        wr(2, 16'h0001);
        wr(1, 16'h0001);
        irq_in[0] = 1;
        tick();
        irq_in[0] = 0;
        tick(2);
        check("edge_not_yet", 16'(int_b), 16'h0003);
        tick();
        check("edge_int_b", 16'(int_b), 16'h0002);
        rd(4, 16'h4000, "edge_vecid");
        rd(0, 16'h0000, "edge_pend_acked");
        check("edge_int_b_clear", 16'(int_b), 16'h0003);

        wr(2, 16'h0024);
        wr(3, 16'h0020);
        wr(1, 16'h00FF);
        wr(5, 16'h0024);
        tick();
        check("prio_int_b", 16'(int_b), 16'h0000);
        rd(4, 16'hC005, "prio_vecid_hi");
        rd(4, 16'h4002, "prio_vecid_lo");
        tick();
        check("prio_int_b_clear", 16'(int_b), 16'h0003);

        wr(2, 16'h0000);
        wr(3, 16'h0000);
        wr(1, 16'h0008);
        wr(5, 16'h0008);
        irq_in[3] = 1;
        tick(3);
        check("level_int_b", 16'(int_b), 16'h0002);
        rd(4, 16'h4003, "level_vecid1");
        rd(4, 16'h4003, "level_vecid2");
        check("level_int_b_held", 16'(int_b), 16'h0002);
        irq_in[3] = 0;
        tick(3);
        check("level_int_b_drop", 16'(int_b), 16'h0003);
        rd(0, 16'h0000, "level_swset_ignored");

        wr(2, 16'h0002);
        wr(1, 16'h0002);
        irq_in[1] = 1;
        tick(2);
        wr(0, 16'h0002);
        rd(0, 16'h0002, "collision_set_wins");
        wr(0, 16'h0002);
        rd(0, 16'h0000, "w1c_clears");
        irq_in[1] = 0;

        wr(2, 16'h0001);
        wr(5, 16'h0001);
        rd(0, 16'h0001, "mode_swset_pend");
        wr(2, 16'h0000);
        rd(0, 16'h0000, "mode_to_level_drop");
        wr(2, 16'h0001);
        rd(0, 16'h0000, "mode_back_no_stale");

        wr(1, 16'h0001);
        clken = 0;
        irq_in[0] = 1;
        tick();
        irq_in[0] = 0;
        wr(1, 16'h00FF);
        tick(8);
        clken = 1;
        tick(5);
        rd(0, 16'h0000, "clken_pulse_missed");
        rd(1, 16'h0001, "clken_write_ignored");
        check("clken_int_b", 16'(int_b), 16'h0003);

        wr(5, 16'h0001);
        reset = 1;
        tick();
        reset = 0;
        rd(0, 16'h0000, "midreset_pend");
        rd(2, 16'h0000, "midreset_mode");
        check("midreset_int_b", 16'(int_b), 16'h0003);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
